// File: rtl/space_race_pkg.sv
// Shared Space Race types: two-digit BCD score, score-channel states and the BCD increment.
// Pure declarations and combinational helpers; no latency, no flow control.
package space_race_pkg;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd2_t;

  typedef enum logic [1:0] {
    IDLE,
    SCORED,
    HOLD
  } ch_state_t;

  localparam int unsigned HOLD_W = 4;

  // Per-nibble increment: units 9 carries into tens, 99 wraps to 00.
  function automatic bcd2_t bcd2_inc(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.units == 4'd9) begin
      r.units = 4'd0;
      if (v.tens == 4'd9) begin
        r.tens = 4'd0;
      end else begin
        r.tens = v.tens + 4'd1;
      end
    end else begin
      r.units = v.units + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/score_channel.sv
// One player's score: falling-edge detect, IDLE/SCORED/HOLD sequencer, BCD score and hold counter.
// Score/restart update two cycles after the fall is sampled; no backpressure, late events are dropped.
module score_channel
  import space_race_pkg::*;
#(
  parameter int unsigned RESTART_FRAMES = 4
) (
  input  logic  CLK_DRV,
  input  logic  RESET,
  input  logic  score,
  input  logic  frame_tick,
  input  logic  score_en,
  input  logic  start,
  input  logic  game_over,
  output bcd2_t bcd,
  output logic  restart
);

  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESTART_FRAMES);

  logic              score_q;
  logic              score_prev;
  logic              score_evt;
  ch_state_t         state;
  logic [HOLD_W-1:0] hold_cnt;

  assign score_evt = score_prev & ~score_q;

  always_ff @(posedge CLK_DRV or posedge RESET) begin
    if (RESET) begin
      score_q    <= 1'b0;
      score_prev <= 1'b0;
      state      <= IDLE;
      bcd        <= '0;
      restart    <= 1'b0;
      hold_cnt   <= '0;
    end else begin
      score_q    <= score;
      score_prev <= score_q;
      if (start) begin
        state    <= IDLE;
        bcd      <= '0;
        restart  <= 1'b0;
        hold_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (score_evt && score_en) begin
              state <= SCORED;
            end
          end
          SCORED: begin
            // The other player may have ended the game one cycle earlier.
            if (!game_over) begin
              bcd <= bcd2_inc(bcd);
            end
            restart  <= 1'b1;
            hold_cnt <= HOLD_INIT;
            state    <= HOLD;
          end
          HOLD: begin
            if (frame_tick) begin
              if (hold_cnt <= 4'd1) begin
                hold_cnt <= '0;
                restart  <= 1'b0;
                state    <= IDLE;
              end else begin
                hold_cnt <= hold_cnt - 4'd1;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Space Race score keeper: two score channels, frame-tick detect, GAME_OVER register and START fan-out.
// BCD/restart two cycles after a SCORE_n fall, GAME_OVER one cycle later; no backpressure.
module score_keeper
  import space_race_pkg::*;
#(
  parameter int unsigned RESTART_FRAMES = 4,
  parameter logic [7:0]  MAX_SCORE      = 8'h99
) (
  input  logic       CLK_DRV,
  input  logic       RESET,
  input  logic       VBLANK_N,
  input  logic       GAME_ON,
  input  logic       START,
  input  logic       SCORE_1,
  input  logic       SCORE_2,
  output logic [7:0] SCORE1_BCD,
  output logic [7:0] SCORE2_BCD,
  output logic       RESTART_1,
  output logic       RESTART_2,
  output logic       GAME_OVER
);

  logic  vblank_q;
  logic  vblank_prev;
  logic  frame_tick;
  logic  score_en;
  bcd2_t bcd1;
  bcd2_t bcd2;

  assign frame_tick = vblank_q & ~vblank_prev;
  assign score_en   = GAME_ON & ~GAME_OVER;

  always_ff @(posedge CLK_DRV or posedge RESET) begin
    if (RESET) begin
      vblank_q    <= 1'b0;
      vblank_prev <= 1'b0;
      GAME_OVER   <= 1'b0;
    end else begin
      vblank_q    <= VBLANK_N;
      vblank_prev <= vblank_q;
      if (START) begin
        GAME_OVER <= 1'b0;
      end else if (bcd1 == MAX_SCORE || bcd2 == MAX_SCORE) begin
        GAME_OVER <= 1'b1;
      end
    end
  end

  score_channel #(
    .RESTART_FRAMES(RESTART_FRAMES)
  ) u_ch1 (
    .CLK_DRV   (CLK_DRV),
    .RESET     (RESET),
    .score     (SCORE_1),
    .frame_tick(frame_tick),
    .score_en  (score_en),
    .start     (START),
    .game_over (GAME_OVER),
    .bcd       (bcd1),
    .restart   (RESTART_1)
  );

  score_channel #(
    .RESTART_FRAMES(RESTART_FRAMES)
  ) u_ch2 (
    .CLK_DRV   (CLK_DRV),
    .RESET     (RESET),
    .score     (SCORE_2),
    .frame_tick(frame_tick),
    .score_en  (score_en),
    .start     (START),
    .game_over (GAME_OVER),
    .bcd       (bcd2),
    .restart   (RESTART_2)
  );

  assign SCORE1_BCD = bcd1;
  assign SCORE2_BCD = bcd2;

endmodule

// File: tb/tb_score_keeper.sv
// Randomised and directed bench for score_keeper against an integer-score reference model.
module tb_score_keeper;

  logic       CLK_DRV;
  logic       RESET;
  logic       VBLANK_N;
  logic       GAME_ON;
  logic       START;
  logic       SCORE_1;
  logic       SCORE_2;
  logic [7:0] SCORE1_BCD;
  logic [7:0] SCORE2_BCD;
  logic       RESTART_1;
  logic       RESTART_2;
  logic       GAME_OVER;

  int errors = 0;
  int checks = 0;

  score_keeper dut (
    .CLK_DRV   (CLK_DRV),
    .RESET     (RESET),
    .VBLANK_N  (VBLANK_N),
    .GAME_ON   (GAME_ON),
    .START     (START),
    .SCORE_1   (SCORE_1),
    .SCORE_2   (SCORE_2),
    .SCORE1_BCD(SCORE1_BCD),
    .SCORE2_BCD(SCORE2_BCD),
    .RESTART_1 (RESTART_1),
    .RESTART_2 (RESTART_2),
    .GAME_OVER (GAME_OVER)
  );

  initial CLK_DRV = 1'b0;
  always #5 CLK_DRV = ~CLK_DRV;

  // Reference model: scores as plain integers 0..99, hold as remaining frame ticks.
  int ms[2];
  int mleft[2];
  bit mr[2];
  bit mpend[2];
  bit sm1[2];
  bit sm2[2];
  bit vm1, vm2;
  bit mgo;
  bit r1_neg;
  int hold_ticks1;

  function automatic logic [7:0] to_bcd(input int s);
    return {4'(s / 10), 4'(s % 10)};
  endfunction

  always @(posedge CLK_DRV or posedge RESET) begin
    if (RESET) begin
      for (int p = 0; p < 2; p++) begin
        ms[p] = 0; mleft[p] = 0; mr[p] = 0; mpend[p] = 0; sm1[p] = 0; sm2[p] = 0;
      end
      vm1 = 0; vm2 = 0; mgo = 0;
    end else begin
      bit tick, go_prev, any_max, evt;
      bit sin[2];
      sin[0] = SCORE_1;
      sin[1] = SCORE_2;
      tick    = !vm2 && vm1;
      go_prev = mgo;
      any_max = (ms[0] == 99) || (ms[1] == 99);
      if (r1_neg && tick) hold_ticks1++;
      for (int p = 0; p < 2; p++) begin
        evt = sm2[p] && !sm1[p];
        if (START) begin
          ms[p] = 0; mr[p] = 0; mpend[p] = 0; mleft[p] = 0;
        end else if (mpend[p]) begin
          if (!go_prev) ms[p] = (ms[p] + 1) % 100;
          mr[p] = 1; mleft[p] = 4; mpend[p] = 0;
        end else if (mr[p]) begin
          if (tick) begin
            mleft[p]--;
            if (mleft[p] == 0) mr[p] = 0;
          end
        end else if (evt && GAME_ON && !go_prev) begin
          mpend[p] = 1;
        end
        sm2[p] = sm1[p];
        sm1[p] = sin[p];
      end
      mgo = START ? 1'b0 : (any_max ? 1'b1 : go_prev);
      vm2 = vm1;
      vm1 = VBLANK_N;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge CLK_DRV) begin
    r1_neg = RESTART_1;
    chk("model", 32'({SCORE1_BCD, SCORE2_BCD, RESTART_1, RESTART_2, GAME_OVER}),
        32'({to_bcd(ms[0]), to_bcd(ms[1]), mr[0], mr[1], mgo}));
  end

  always @(posedge CLK_DRV) begin
    #1 VBLANK_N = 1'($urandom_range(0, 1));
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK_DRV);
    #1;
  endtask

  // Leaves time just after the edge at which the event is registered (N+1).
  task automatic pulse(input bit p1, input bit p2);
    if (p1) SCORE_1 = 1'b0;
    if (p2) SCORE_2 = 1'b0;
    cyc(1);
    SCORE_1 = 1'b1;
    SCORE_2 = 1'b1;
    cyc(1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((mpend[0] || mpend[1] || mr[0] || mr[1] || RESTART_1 || RESTART_2) && n < 300) begin
      cyc(1);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: timeout after %0d cycles", n);
    end
    cyc(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    RESET = 1'b1; VBLANK_N = 1'b0; GAME_ON = 1'b0; START = 1'b0;
    SCORE_1 = 1'b1; SCORE_2 = 1'b1;
    r1_neg = 1'b0; hold_ticks1 = 0;
    cyc(3);
    chk("reset_outputs", 32'({SCORE1_BCD, SCORE2_BCD, RESTART_1, RESTART_2, GAME_OVER}), 32'h0);
    RESET = 1'b0;
    GAME_ON = 1'b1;
    cyc(3);

    // First score: latency and 4-tick hold.
    hold_ticks1 = 0;
    pulse(1, 0);
    chk("latency_n1", 32'(SCORE1_BCD), 32'h00);
    cyc(1);
    chk("first_score", 32'(SCORE1_BCD), 32'h01);
    chk("first_restart", 32'(RESTART_1), 32'h1);
    chk("first_other", 32'(SCORE2_BCD), 32'h00);
    wait_idle();
    chk("hold_ticks", 32'(hold_ticks1), 32'd4);

    // Carry from units into tens.
    for (int i = 2; i <= 10; i++) begin
      pulse(1, 0);
      cyc(1);
      if (i == 9) chk("score_09", 32'(SCORE1_BCD), 32'h09);
      if (i == 10) chk("score_10", 32'(SCORE1_BCD), 32'h10);
      wait_idle();
    end

    // Simultaneous scores.
    pulse(1, 1);
    cyc(1);
    chk("both_s1", 32'(SCORE1_BCD), 32'h11);
    chk("both_s2", 32'(SCORE2_BCD), 32'h01);
    chk("both_restart", 32'({RESTART_1, RESTART_2}), 32'h3);
    wait_idle();

    // Climb to 98, then reach 99 and freeze.
    while (ms[0] < 98) begin
      pulse(1, 0);
      wait_idle();
    end
    chk("score_98", 32'(SCORE1_BCD), 32'h98);
    pulse(1, 0);
    cyc(1);
    chk("score_99", 32'(SCORE1_BCD), 32'h99);
    chk("go_not_yet", 32'(GAME_OVER), 32'h0);
    cyc(1);
    chk("game_over", 32'(GAME_OVER), 32'h1);
    wait_idle();
    pulse(1, 0);
    cyc(4);
    chk("frozen", 32'(SCORE1_BCD), 32'h99);
    chk("frozen_restart", 32'(RESTART_1), 32'h0);

    // START mid-HOLD at 05 with a coincident SCORE_2 event.
    START = 1'b1;
    cyc(1);
    START = 1'b0;
    chk("start_clear_go", 32'(GAME_OVER), 32'h0);
    for (int i = 0; i < 4; i++) begin
      pulse(1, 0);
      wait_idle();
    end
    pulse(1, 0);
    cyc(1);
    chk("score_05", 32'(SCORE1_BCD), 32'h05);
    cyc(1);
    SCORE_2 = 1'b0;
    cyc(1);
    START = 1'b1;
    SCORE_2 = 1'b1;
    cyc(1);
    START = 1'b0;
    chk("start_mid_hold", 32'({SCORE1_BCD, RESTART_1, GAME_OVER}), 32'h000);
    cyc(4);
    chk("start_ignores_evt", 32'({SCORE2_BCD, RESTART_2}), 32'h000);

    // GAME_ON low blocks scoring.
    GAME_ON = 1'b0;
    pulse(0, 1);
    cyc(6);
    chk("game_off", 32'({SCORE2_BCD, RESTART_2}), 32'h000);
    GAME_ON = 1'b1;

    // Asynchronous reset mid-HOLD.
    pulse(0, 1);
    cyc(1);
    chk("p2_score", 32'({SCORE2_BCD, RESTART_2}), 32'h003);
    cyc(1);
    @(posedge CLK_DRV);
    #3 RESET = 1'b1;
    #1 chk("async_reset", 32'({SCORE1_BCD, SCORE2_BCD, RESTART_1, RESTART_2, GAME_OVER}), 32'h0);
    @(posedge CLK_DRV);
    #1 RESET = 1'b0;
    cyc(2);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      SCORE_1 = ($urandom_range(0, 7) != 0);
      SCORE_2 = ($urandom_range(0, 7) != 0);
      GAME_ON = ($urandom_range(0, 20) != 0);
      START   = ($urandom_range(0, 400) == 0);
      cyc(1);
    end
    START = 1'b0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
